time_counter: RTL and testbench
===============================

TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter: p_hours, default 24, hour modulus; legal range 1..24.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_tick  input  1  one-cycle count-enable pulse from the clock divider, one pulse per second.
REQ-005 i_start  input  1  level; requests counting.
REQ-006 i_stop  input  1  level; requests halt.
REQ-007 i_load  input  1  one-cycle request to load i_time.
REQ-008 i_time  input  24  load value, packed BCD {HH[23:16], MM[15:8], SS[7:0]}, each byte {tens[7:4], units[3:0]}.
REQ-009 o_time  output  24  current time, same packing as i_time, registered.
REQ-010 o_carry  output  1  one-cycle pulse on hour wrap to 00:00:00.
REQ-011 o_err  output  1  one-cycle pulse on a rejected load.
REQ-012 o_run  output  1  high while in RUN.
REQ-013 o_hold  output  1  high whenever state is not RUN; drives the divider's stop input to freeze its phase.

Function
REQ-014 FSM states: STOP, RUN, LOAD; state encoding is free.
REQ-015 STOP transitions: valid i_load -> LOAD; otherwise i_start=1 and i_stop=0 -> RUN; otherwise stay.
REQ-016 RUN transitions: valid i_load -> LOAD; otherwise i_stop=1 -> STOP; otherwise stay.
REQ-017 LOAD behaviour: lasts exactly one cycle, writes the captured i_time into o_time, then -> STOP unconditionally.
REQ-018 Load capture: i_time is registered in the cycle i_load is sampled; o_time shows it 2 cycles after the i_load cycle.
REQ-019 Load validity: every units digit <= 9, MM tens <= 5, SS tens <= 5, binary HH value < p_hours.
REQ-020 Invalid load: state unchanged, o_time unchanged, o_err=1 in the next cycle for exactly one cycle.
REQ-021 Counting scope: i_tick is counted only in RUN; i_tick in STOP or LOAD is discarded, not deferred.
REQ-022 Tick latency: i_tick sampled high in RUN updates o_time on that edge; the new value is visible the next cycle.
REQ-023 SS increment: units 0..9; at 9 -> units 0 and tens +1; at 59 -> SS 00 and carry into MM.
REQ-024 MM increment: same as SS (00..59); at 59 with carry -> MM 00 and carry into HH.
REQ-025 HH increment: counts 00..p_hours-1 in BCD; 09 -> 10 and 19 -> 20 via a units-digit reset.
REQ-026 Day wrap: at HH=p_hours-1, MM=59, SS=59 a tick -> 00:00:00 and o_carry=1 on the same edge as o_time.
REQ-027 o_carry width: high for exactly one cycle per wrap.
REQ-028 Tick and i_stop together in RUN: the tick is counted, then the FSM goes to STOP.
REQ-029 Tick and valid i_load together in RUN: the load wins and the tick is dropped.
REQ-030 i_start and i_stop together: i_stop has priority.
REQ-031 Output timing: o_run and o_hold are decoded from the registered state, with no combinational path from any input.
REQ-032 o_time contents: always valid BCD within range; no illegal digit is ever produced.

Reset
REQ-033 Reset values: asserting i_rst forces, asynchronously, state=STOP, o_time=24'h000000, o_carry=0, o_err=0, o_run=0, o_hold=1.
REQ-034 Reset mid-operation: reset during RUN or LOAD discards any pending load or tick.
REQ-035 After release: after i_rst deasserts, the block stays in STOP until i_start or i_load.
REQ-036 Reset release timing: release is synchronised internally; the first state change occurs no earlier than the second rising edge after deassertion.

Verification
REQ-037 Load and single tick: load 24'h235958, start, 1 tick -> o_time=24'h235959, o_carry=0.
REQ-038 Day wrap: load 24'h235959, start, 1 tick -> o_time=24'h000000, o_carry=1 for one cycle.
REQ-039 Invalid load: from 24'h120000, load 24'h126000 -> o_err one cycle, o_time stays 24'h120000, state unchanged.
REQ-040 Stop/start: in RUN, tick and i_stop in the same cycle -> count +1, o_hold=1; further ticks ignored; i_start -> o_run=1, counting resumes.
REQ-041 Load beats tick: in RUN at 24'h000009, tick with load 24'h010203 -> o_time=24'h010203, state STOP.
REQ-042 Reset mid-run: assert i_rst mid-RUN at 24'h101010 -> o_time=24'h000000, o_hold=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/time_counter.sv
// Time-of-day counter: packed BCD HH:MM:SS advanced by a one-per-second tick.
// Supports validated loads, run/stop control, and a carry pulse when the day wraps.
module time_counter #(
  parameter int unsigned p_hours = 24
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_load,
  input  logic [23:0] i_time,
  output logic [23:0] o_time,
  output logic        o_carry,
  output logic        o_err,
  output logic        o_run,
  output logic        o_hold
);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam logic [7:0] HH_LIMIT    = 8'(p_hours);
  localparam logic [7:0] HH_LAST_BCD = {4'((p_hours - 1) / 10), 4'((p_hours - 1) % 10)};

  logic [1:0]  state_q, state_d;
  logic [23:0] time_q, time_d;
  logic [23:0] cap_q, cap_d;
  logic        carry_q, carry_d;
  logic        err_q, err_d;
  logic [1:0]  rst_sync_q, rst_sync_d;

  logic        load_ok;
  logic [7:0]  ld_hh_bin;
  logic [23:0] time_inc;
  logic        ss_wrap, mm_wrap, day_wrap;
  logic [7:0]  hh_inc;

  // Advance a 00..59 BCD byte by one, wrapping 59 back to 00.
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Load-value validation: legal BCD digits, minutes/seconds below 60, hours below the modulus.
  always_comb begin
    ld_hh_bin = ({4'd0, i_time[23:20]} * 8'd10) + {4'd0, i_time[19:16]};
    load_ok   = (i_time[19:16] <= 4'd9) && (i_time[11:8] <= 4'd9) && (i_time[3:0] <= 4'd9) &&
                (i_time[15:12] <= 4'd5) && (i_time[7:4] <= 4'd5) && (ld_hh_bin < HH_LIMIT);
  end

  // Next time value for one tick, with ripple carry SS -> MM -> HH and day wrap.
  always_comb begin
    ss_wrap  = (time_q[7:0] == 8'h59);
    mm_wrap  = (time_q[15:8] == 8'h59);
    day_wrap = ss_wrap && mm_wrap && (time_q[23:16] == HH_LAST_BCD);
    if (time_q[23:16] == HH_LAST_BCD) begin
      hh_inc = 8'h00;
    end else if (time_q[19:16] == 4'd9) begin
      hh_inc = {time_q[23:20] + 4'd1, 4'd0};
    end else begin
      hh_inc = {time_q[23:20], time_q[19:16] + 4'd1};
    end
    time_inc[7:0]   = bcd_inc60(time_q[7:0]);
    time_inc[15:8]  = ss_wrap ? bcd_inc60(time_q[15:8]) : time_q[15:8];
    time_inc[23:16] = (ss_wrap && mm_wrap) ? hh_inc : time_q[23:16];
  end

  // FSM and datapath next-state; nothing moves until the reset synchroniser has drained.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    cap_d      = cap_q;
    carry_d    = 1'b0;
    err_d      = 1'b0;
    rst_sync_d = {rst_sync_q[0], 1'b0};
    if (!rst_sync_q[1]) begin
      case (state_q)
        ST_STOP: begin
          if (i_load) begin
            if (load_ok) begin
              cap_d   = i_time;
              state_d = ST_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end else if (i_start && !i_stop) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // A load request (valid or not) suppresses the tick and stop in this cycle.
          if (i_load) begin
            if (load_ok) begin
              cap_d   = i_time;
              state_d = ST_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (i_tick) begin
              time_d  = time_inc;
              carry_d = day_wrap;
            end
            if (i_stop) begin
              state_d = ST_STOP;
            end
          end
        end
        ST_LOAD: begin
          time_d  = cap_q;
          state_d = ST_STOP;
        end
        default: state_d = ST_STOP;
      endcase
    end
  end

  // State registers with asynchronous reset; synchroniser holds off the first update.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_STOP;
      time_q     <= '0;
      cap_q      <= '0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
      rst_sync_q <= '1;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      cap_q      <= cap_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    o_time  = time_q;
    o_carry = carry_q;
    o_err   = err_q;
    o_run   = (state_q == ST_RUN);
    o_hold  = (state_q != ST_RUN);
  end

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter with hand-computed expectations.
module tb_time_counter;

  logic        clk;
  logic        rst;
  logic        tick, start, stop, load;
  logic [23:0] tin;
  logic [23:0] tout;
  logic        carry, err, run, hold;

  int unsigned n_checks;
  int unsigned n_fail;

  time_counter #(.p_hours(24)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_tick (tick),
    .i_start(start),
    .i_stop (stop),
    .i_load (load),
    .i_time (tin),
    .o_time (tout),
    .o_carry(carry),
    .o_err  (err),
    .o_run  (run),
    .o_hold (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns shortly after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Valid load from STOP or RUN: new value visible two edges after the request.
  task automatic do_load(input logic [23:0] v);
    load = 1'b1;
    tin  = v;
    step();
    load = 1'b0;
    chk("load_hold", {31'd0, hold}, 32'd1);
    step();
    chk("load_val", {8'd0, tout}, {8'd0, v});
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_run", {31'd0, run}, 32'd1);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic wait_run(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (run) break;
      step();
    end
    chk(tag, {31'd0, run}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; tin = '0;
    step();
    step();
    chk("rst_time", {8'd0, tout}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_hold", {31'd0, hold}, 32'd1);

    // Release with start already requested: first edge must not change state.
    rst   = 1'b0;
    start = 1'b1;
    step();
    chk("rel_edge1", {31'd0, run}, 32'd0);
    wait_run("rel_run", 6);
    start = 1'b0;
    stop  = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_hold", {31'd0, hold}, 32'd1);

    // Load then single tick, then day wrap.
    do_load(24'h235958);
    do_start();
    do_tick();
    chk("tick_235959", {8'd0, tout}, 32'h235959);
    chk("tick_nocarry", {31'd0, carry}, 32'd0);
    do_tick();
    chk("wrap_time", {8'd0, tout}, 32'h000000);
    chk("wrap_carry", {31'd0, carry}, 32'd1);
    step();
    chk("wrap_carry_1cyc", {31'd0, carry}, 32'd0);

    // Count up to 00:00:09 then tick together with a load: load wins.
    for (int unsigned i = 0; i < 9; i++) begin
      do_tick();
      step();
    end
    chk("cnt_000009", {8'd0, tout}, 32'h000009);
    tick = 1'b1;
    do_load(24'h010203);
    tick = 1'b0;
    chk("loadwin_stop", {31'd0, run}, 32'd0);

    // Hour carries through units-digit reset.
    do_load(24'h095959);
    do_start();
    do_tick();
    chk("hh_09_10", {8'd0, tout}, 32'h100000);
    do_load(24'h195959);
    do_start();
    do_tick();
    chk("hh_19_20", {8'd0, tout}, 32'h200000);
    do_load(24'h005959);
    do_start();
    do_tick();
    chk("mm_carry", {8'd0, tout}, 32'h010000);

    // Invalid loads from STOP: error pulse, time and state unchanged.
    do_load(24'h120000);
    load = 1'b1; tin = 24'h126000;
    step();
    load = 1'b0;
    chk("inv_mm_err", {31'd0, err}, 32'd1);
    chk("inv_mm_time", {8'd0, tout}, 32'h120000);
    chk("inv_mm_state", {31'd0, run}, 32'd0);
    step();
    chk("inv_err_1cyc", {31'd0, err}, 32'd0);
    chk("inv_time_kept", {8'd0, tout}, 32'h120000);
    load = 1'b1; tin = 24'h240000;
    step();
    load = 1'b0;
    chk("inv_hh24_err", {31'd0, err}, 32'd1);
    load = 1'b1; tin = 24'h1A0000;
    step();
    load = 1'b0;
    chk("inv_hhu_err", {31'd0, err}, 32'd1);
    load = 1'b1; tin = 24'h235960;
    step();
    load = 1'b0;
    chk("inv_ss_err", {31'd0, err}, 32'd1);
    step();
    chk("inv_all_time", {8'd0, tout}, 32'h120000);

    // Invalid load while running keeps RUN and the time.
    do_start();
    load = 1'b1; tin = 24'h129900;
    step();
    load = 1'b0;
    chk("inv_run_err", {31'd0, err}, 32'd1);
    chk("inv_run_state", {31'd0, run}, 32'd1);
    chk("inv_run_time", {8'd0, tout}, 32'h120000);

    // Tick with stop: counted, then halted; later ticks ignored; restart resumes.
    do_load(24'h000100);
    do_start();
    tick = 1'b1; stop = 1'b1;
    step();
    tick = 1'b0; stop = 1'b0;
    chk("tickstop_time", {8'd0, tout}, 32'h000101);
    chk("tickstop_hold", {31'd0, hold}, 32'd1);
    do_tick();
    do_tick();
    chk("stop_ignore", {8'd0, tout}, 32'h000101);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("stop_prio", {31'd0, run}, 32'd0);
    do_start();
    do_tick();
    chk("resume", {8'd0, tout}, 32'h000102);

    // Asynchronous reset mid-run.
    do_load(24'h101010);
    do_start();
    rst = 1'b1;
    #2;
    chk("async_time", {8'd0, tout}, 32'h000000);
    chk("async_hold", {31'd0, hold}, 32'd1);
    step();
    rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      do_tick();
    end
    chk("post_rst_stay", {31'd0, run}, 32'd0);
    chk("post_rst_time", {8'd0, tout}, 32'h000000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
